quad_step_decoder: RTL and testbench
====================================

Name: quad_step_decoder

Overview:
- Quadrature front end that sits directly upstream of the 4-bit up/down loadable counter.
- Turns raw encoder phases A/B and an index input into the counter's control signals:
  - a single-cycle count enable,
  - a direction level,
  - a single-cycle load pulse.
- Provides input synchronisation, glitch filtering, x4 Gray-code decoding and sticky illegal-transition detection.

Parameters:
- SYNC_STAGES, 2, synchroniser depth per input (legal range 2..4).
- FILTER_LEN, 3, consecutive identical synchronised samples required before a filtered level changes (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock, same clock as the counter.
- rst  input  1  asynchronous, active-high reset.
- a_in  input  1  encoder phase A, asynchronous.
- b_in  input  1  encoder phase B, asynchronous.
- idx_in  input  1  encoder index, asynchronous; rising edge requests a counter load.
- err_clr  input  1  synchronous clear of err_out.
- en_out  output  1  one-cycle step pulse; drives the counter enable.
- dir_out  output  1  0 = increment, 1 = decrement; drives the counter direction.
- load_out  output  1  one-cycle pulse; drives the counter load select.
- err_out  output  1  sticky illegal-transition flag.

Behaviour:
- Reset (async, active-high):
  - All flops clear: synchronisers, filter counters, filtered levels, previous-state register, outputs.
  - en_out = 0, dir_out = 0, load_out = 0, err_out = 0.
  - FSM enters INIT.
- Synchronisers:
  - a_in, b_in and idx_in each pass through SYNC_STAGES flops.
  - The last stage is the synchronised value (a_s, b_s, i_s).
- Filter (per channel):
  - Counter of width ceil(log2(FILTER_LEN+1)).
  - While the synchronised value differs from the filtered level, the counter increments; any agreement resets it to 0.
  - When the counter would reach FILTER_LEN, the filtered level takes the synchronised value and the counter resets.
  - A pulse shorter than FILTER_LEN cycles is rejected completely.
- FSM:
  - INIT:
    - Down-counter loads SYNC_STAGES+FILTER_LEN at reset and decrements each cycle.
    - Filtered levels are loaded directly from the synchronised values each cycle, with no pulses generated.
    - At 0: previous-state register = {a_f, b_f}, prev_idx = i_f; go to RUN.
  - RUN:
    - Each cycle compare cur = {a_f, b_f} with prev, then update prev = cur.
    - Up sequence 00→01→11→10→00: en_out = 1, dir_out = 0 next cycle.
    - Reverse sequence: en_out = 1, dir_out = 1 next cycle.
    - cur == prev: en_out = 0, dir_out holds its last value.
    - Both bits changed (00↔11, 01↔10): en_out = 0, dir_out holds, err_out set.
  - No return to INIT except via rst.
- Index:
  - load_out = 1 for exactly one cycle when i_f rises (prev_idx = 0, i_f = 1) in RUN.
  - A falling edge produces nothing.
- Simultaneous step and load:
  - Both pulses are asserted in the same cycle.
  - The counter's load has priority, so that step is intentionally lost.
- err_out:
  - Set in the cycle after an illegal transition; remains set until err_clr or rst.
  - err_clr and a new illegal transition in the same cycle: set wins.
- Latency in RUN: a clean level change on a_in/b_in/idx_in first sampled at edge k gives an output pulse at edge k+SYNC_STAGES+FILTER_LEN. Defaults give 5 cycles.
- Throughput and outputs:
  - At most one step per cycle.
  - Phases toggling faster than FILTER_LEN cycles are filtered out, not counted.
  - All outputs are registered, so there is no combinational path from any input.
- Reset mid-operation:
  - Pulses are aborted immediately and err_out clears.
  - Re-entering INIT guarantees no spurious step or load from the current input levels.

Test Plan:
- Reset release with a_in = b_in = 1, idx_in = 1 held → no en_out/load_out for 20 cycles; FSM in RUN after 5 cycles.
- Forward sequence 00→01→11→10→00, each level held 8 cycles → 4 en_out pulses with dir_out = 0, each 5 cycles after its edge.
- Reverse sequence → 4 pulses with dir_out = 1; the downstream counter loaded with 0 reads 12 (4'hC).
- 2-cycle glitch on a_in with FILTER_LEN = 3 → no en_out, err_out stays 0; a 3-cycle pulse → exactly one step followed by one reverse step.
- Step 00→11 applied to both phases in one cycle → err_out = 1 five cycles later with no en_out; err_clr pulse → err_out = 0. Then idx_in rising edge concurrent with a phase step → load_out and en_out both high for one cycle.
- Assert rst for 1 cycle during a forward sequence → all outputs 0 within the same cycle; after INIT, counting resumes with no extra pulse.

Source files
------------

// File: rtl/quad_step_decoder.sv
// Quadrature front end: synchronises and glitch-filters encoder phases A/B and index,
// then decodes x4 Gray steps into counter enable/direction/load pulses with a sticky error flag.
module quad_step_decoder #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic a_in,
   input  logic b_in,
   input  logic idx_in,
   input  logic err_clr,
   output logic en_out,
   output logic dir_out,
   output logic load_out,
   output logic err_out
);

   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam int IW = $clog2(SYNC_STAGES + FILTER_LEN + 1);
   localparam logic [IW-1:0] INIT_CNT = IW'(SYNC_STAGES + FILTER_LEN);
   localparam logic [CW-1:0] FLEN     = CW'(FILTER_LEN);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Gray-step classification: 2'b01 up, 2'b10 down, 2'b11 illegal, 2'b00 no change
   function automatic logic [1:0] classify(input logic [1:0] prev, input logic [1:0] cur);
      logic [1:0] res;
      case ({prev, cur})
         4'b0001, 4'b0111, 4'b1110, 4'b1000: res = 2'b01;
         4'b0010, 4'b1011, 4'b1101, 4'b0100: res = 2'b10;
         4'b0011, 4'b1100, 4'b0110, 4'b1001: res = 2'b11;
         default:                            res = 2'b00;
      endcase
      return res;
   endfunction

   // channel bit order everywhere: {a, b, idx}
   logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
   logic [2:0][CW-1:0]          fcnt_q, fcnt_d;
   logic [2:0]                  filt_q, filt_d;
   logic [2:0]                  raw_s, syn_s;
   logic [1:0]                  step_s;
   state_t                      state_q, state_d;
   logic [IW-1:0]               init_cnt_q, init_cnt_d;
   logic [1:0]                  prev_q, prev_d;
   logic                        prev_idx_q, prev_idx_d;
   logic                        en_q, en_d;
   logic                        dir_q, dir_d;
   logic                        load_q, load_d;
   logic                        err_q, err_d;

   assign raw_s  = {a_in, b_in, idx_in};
   assign syn_s  = sync_q[SYNC_STAGES-1];
   assign step_s = classify(prev_q, filt_q[2:1]);

   // Next-state logic: synchroniser shift, INIT settling, filtering and step decode
   always_comb begin
      sync_d     = sync_q;
      fcnt_d     = fcnt_q;
      filt_d     = filt_q;
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      prev_d     = prev_q;
      prev_idx_d = prev_idx_q;
      en_d       = 1'b0;
      dir_d      = dir_q;
      load_d     = 1'b0;
      if (err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end

      sync_d[0] = raw_s;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end

      case (state_q)
         ST_INIT: begin
            // Track inputs directly so RUN starts from the settled levels without pulses
            filt_d = syn_s;
            fcnt_d = '0;
            if (init_cnt_q == IW'(1)) begin
               state_d    = ST_RUN;
               init_cnt_d = {IW{1'b0}};
               prev_d     = syn_s[2:1];
               prev_idx_d = syn_s[0];
            end else begin
               init_cnt_d = init_cnt_q - IW'(1);
            end
         end
         ST_RUN: begin
            for (int c = 0; c < 3; c++) begin
               if (syn_s[c] != filt_q[c]) begin
                  if ((fcnt_q[c] + CW'(1)) == FLEN) begin
                     filt_d[c] = syn_s[c];
                     fcnt_d[c] = {CW{1'b0}};
                  end else begin
                     fcnt_d[c] = fcnt_q[c] + CW'(1);
                  end
               end else begin
                  fcnt_d[c] = {CW{1'b0}};
               end
            end
            case (step_s)
               2'b01: begin
                  en_d  = 1'b1;
                  dir_d = 1'b0;
               end
               2'b10: begin
                  en_d  = 1'b1;
                  dir_d = 1'b1;
               end
               2'b11:   err_d = 1'b1;
               default: en_d  = 1'b0;
            endcase
            load_d     = filt_q[0] & ~prev_idx_q;
            prev_d     = filt_q[2:1];
            prev_idx_d = filt_q[0];
         end
         default: state_d = ST_INIT;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q     <= '0;
         fcnt_q     <= '0;
         filt_q     <= 3'b000;
         state_q    <= ST_INIT;
         init_cnt_q <= INIT_CNT;
         prev_q     <= 2'b00;
         prev_idx_q <= 1'b0;
         en_q       <= 1'b0;
         dir_q      <= 1'b0;
         load_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         fcnt_q     <= fcnt_d;
         filt_q     <= filt_d;
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         prev_q     <= prev_d;
         prev_idx_q <= prev_idx_d;
         en_q       <= en_d;
         dir_q      <= dir_d;
         load_q     <= load_d;
         err_q      <= err_d;
      end
   end

   assign en_out   = en_q;
   assign dir_out  = dir_q;
   assign load_out = load_q;
   assign err_out  = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: cycle-accurate reference model built from the delay/window
// filter rule and Gray position arithmetic, plus hand-computed pulse counts and latencies.
module tb_quad_step_decoder;

   localparam int S   = 2;
   localparam int F   = 3;
   localparam int LAT = S + F;

   logic clk = 1'b0;
   logic rst, a_in, b_in, idx_in, err_clr;
   logic en_out, dir_out, load_out, err_out;

   quad_step_decoder #(.SYNC_STAGES(S), .FILTER_LEN(F)) dut (
      .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .idx_in(idx_in), .err_clr(err_clr),
      .en_out(en_out), .dir_out(dir_out), .load_out(load_out), .err_out(err_out)
   );

   always #5 clk = ~clk;

   // Reference model state (cyc counts clock edges since reset release)
   int         cyc;
   logic [2:0] samp [0:4095];
   logic [2:0] lvl;
   logic [1:0] prev;
   logic       prev_idx;
   logic       exp_en, exp_dir, exp_load, exp_err;

   function automatic int pos(input logic [1:0] v);
      case (v)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         2'b10:   return 3;
         default: return 0;
      endcase
   endfunction

   // value seen by the filter at edge mm: the input sampled S edges earlier
   function automatic logic [2:0] dly(input int mm);
      if (mm - S >= 1) return samp[mm - S];
      return 3'b000;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc = 0; lvl = 3'b000; prev = 2'b00; prev_idx = 1'b0;
         exp_en = 1'b0; exp_dir = 1'b0; exp_load = 1'b0; exp_err = 1'b0;
      end else begin
         logic [2:0] d, dv;
         int         delta;
         bit         all_diff;
         if (cyc < 4095) cyc = cyc + 1;
         samp[cyc] = {a_in, b_in, idx_in};
         d = dly(cyc);
         if (cyc <= LAT) begin
            exp_en = 1'b0; exp_load = 1'b0;
            if (err_clr) exp_err = 1'b0;
            lvl = d;
            if (cyc == LAT) begin
               prev = d[2:1]; prev_idx = d[0];
            end
         end else begin
            delta  = (pos(lvl[2:1]) - pos(prev)) & 3;
            exp_en = (delta == 1) || (delta == 3);
            if (delta == 1) exp_dir = 1'b0;
            else if (delta == 3) exp_dir = 1'b1;
            if (delta == 2) exp_err = 1'b1;
            else if (err_clr) exp_err = 1'b0;
            exp_load = lvl[0] & ~prev_idx;
            prev = lvl[2:1]; prev_idx = lvl[0];
            // a level flips once the last F filter samples (all within RUN) disagree with it
            for (int c = 0; c < 3; c++) begin
               all_diff = 1'b1;
               for (int j = 0; j < F; j++) begin
                  dv = dly(cyc - j);
                  if ((cyc - j) <= LAT || dv[c] == lvl[c]) all_diff = 1'b0;
               end
               if (all_diff) lvl[c] = ~lvl[c];
            end
         end
      end
   end

   int         n_chk = 0, n_err = 0;
   int         en_cnt = 0, up_cnt = 0, load_cnt = 0, both_cnt = 0;
   int         last_en_cyc = -1, err_rise_cyc = -1;
   logic [3:0] ctr = 4'h0;
   logic       err_seen = 1'b0;
   bit         chk_on = 1'b0;
   int         s0, u0, l0, b0, k;
   logic [3:0] c0, cdiff;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic set_ab(input logic a, input logic b, input int n);
      a_in = a; b_in = b;
      hold(n);
   endtask

   initial begin
      rst = 1'b1; a_in = 1'b1; b_in = 1'b1; idx_in = 1'b1; err_clr = 1'b0;
      fork
         forever begin
            @(posedge clk);
            #1;
            if (chk_on) begin
               chk("en_out", en_out, exp_en);
               chk("dir_out", dir_out, exp_dir);
               chk("load_out", load_out, exp_load);
               chk("err_out", err_out, exp_err);
               if (en_out) begin
                  en_cnt++;
                  last_en_cyc = cyc;
                  if (dir_out) ctr = ctr - 4'h1;
                  else begin ctr = ctr + 4'h1; up_cnt++; end
               end
               if (load_out) load_cnt++;
               if (en_out && load_out) both_cnt++;
               if (err_out && !err_seen) err_rise_cyc = cyc;
               err_seen = err_out;
            end
         end
         begin
            hold(3);
            chk("reset_en", en_out, 0);
            chk("reset_dir", dir_out, 0);
            chk("reset_load", load_out, 0);
            chk("reset_err", err_out, 0);
            chk_on = 1'b1;
            rst = 1'b0;
            s0 = en_cnt; l0 = load_cnt;
            hold(20);
            chk("init_no_en", en_cnt - s0, 0);
            chk("init_no_load", load_cnt - l0, 0);

            // move 11 -> 10 -> 00 forward, index falls silently
            idx_in = 1'b0;
            set_ab(1'b1, 1'b0, 8);
            set_ab(1'b0, 1'b0, 8);
            chk("pre_err", err_out, 0);

            // forward sequence with latency check on first edge
            s0 = en_cnt; u0 = up_cnt; k = cyc + 1;
            set_ab(1'b0, 1'b1, 8);
            chk("fwd_latency", last_en_cyc, k + 5);
            set_ab(1'b1, 1'b1, 8);
            set_ab(1'b1, 1'b0, 8);
            set_ab(1'b0, 1'b0, 8);
            chk("fwd_steps", en_cnt - s0, 4);
            chk("fwd_up", up_cnt - u0, 4);

            // reverse sequence: counter from 0 ends at 4'hC
            s0 = en_cnt; c0 = ctr;
            set_ab(1'b1, 1'b0, 8);
            set_ab(1'b1, 1'b1, 8);
            set_ab(1'b0, 1'b1, 8);
            set_ab(1'b0, 1'b0, 8);
            chk("rev_steps", en_cnt - s0, 4);
            cdiff = ctr - c0;
            chk("rev_ctr", cdiff, 12);

            // 2-cycle glitch rejected, 3-cycle pulse accepted
            s0 = en_cnt;
            set_ab(1'b1, 1'b0, 2);
            set_ab(1'b0, 1'b0, 12);
            chk("glitch_no_en", en_cnt - s0, 0);
            chk("glitch_no_err", err_out, 0);
            s0 = en_cnt; u0 = up_cnt;
            set_ab(1'b1, 1'b0, 3);
            set_ab(1'b0, 1'b0, 12);
            chk("pulse3_steps", en_cnt - s0, 2);
            chk("pulse3_up", up_cnt - u0, 1);

            // illegal 00 -> 11
            s0 = en_cnt; k = cyc + 1;
            set_ab(1'b1, 1'b1, 10);
            chk("illegal_no_en", en_cnt - s0, 0);
            chk("illegal_err", err_out, 1);
            chk("illegal_err_time", err_rise_cyc, k + 5);
            err_clr = 1'b1;
            hold(1);
            err_clr = 1'b0;
            hold(2);
            chk("err_cleared", err_out, 0);

            // index rise together with a phase step (11 -> 01)
            b0 = both_cnt; l0 = load_cnt;
            a_in = 1'b0; idx_in = 1'b1;
            hold(10);
            chk("load_and_step", both_cnt - b0, 1);
            chk("load_once", load_cnt - l0, 1);

            // reset in the middle of a forward step
            set_ab(1'b1, 1'b1, 8);
            set_ab(1'b1, 1'b0, 3);
            rst = 1'b1;
            #1;
            chk("midrst_en", en_out, 0);
            chk("midrst_dir", dir_out, 0);
            chk("midrst_load", load_out, 0);
            chk("midrst_err", err_out, 0);
            hold(1);
            rst = 1'b0;
            s0 = en_cnt; l0 = load_cnt;
            hold(25);
            chk("post_rst_no_en", en_cnt - s0, 0);
            chk("post_rst_no_load", load_cnt - l0, 0);
            s0 = en_cnt; u0 = up_cnt;
            set_ab(1'b0, 1'b0, 10);
            chk("post_rst_step", en_cnt - s0, 1);
            chk("post_rst_up", up_cnt - u0, 1);
         end
      join_any
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
